// File: rtl/c7bexu_ecl_byp.sv
// Execution-control side of the E/M/W operand bypass: pipelines destination
// tags from E to W, drives the one-hot operand mux selects and the load-use stall.
module c7bexu_ecl_byp #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_e,
    input  logic [AW-1:0] rd_e,
    input  logic          wen_e,
    input  logic          load_e,
    input  logic [AW-1:0] rs1_e,
    input  logic [AW-1:0] rs2_e,
    input  logic          rs1_ren_e,
    input  logic          rs2_ren_e,
    input  logic          flush_e,
    input  logic          hold,
    output logic [AW-1:0] rd_m,
    output logic          wen_m,
    output logic [AW-1:0] rd_w,
    output logic          wen_w,
    output logic          ecl_byp_rs1_mux_sel_rf,
    output logic          ecl_byp_rs1_mux_sel_m,
    output logic          ecl_byp_rs1_mux_sel_w,
    output logic          ecl_byp_rs2_mux_sel_rf,
    output logic          ecl_byp_rs2_mux_sel_m,
    output logic          ecl_byp_rs2_mux_sel_w,
    output logic          ldu_stall_e
);

    localparam logic [AW-1:0] REG_X0 = {AW{1'b0}};

    logic [AW-1:0] rd_m_r;
    logic          wen_m_r;
    logic          load_m_r;
    logic [AW-1:0] rd_w_r;
    logic          wen_w_r;

    logic          hitm_rs1_s;
    logic          hitm_rs2_s;
    logic          hitw_rs1_s;
    logic          hitw_rs2_s;
    logic          ldu_stall_s;
    logic          wen_qual_s;
    logic [2:0]    rs1_sel_s;
    logic [2:0]    rs2_sel_s;

    // Source matches a producer tag; x0 never matches so it always reads the RF.
    function automatic logic reg_hit(
        input logic          ren,
        input logic          wen,
        input logic [AW-1:0] rd,
        input logic [AW-1:0] rs
    );
        return ren & wen & (rd == rs) & (rs != REG_X0);
    endfunction

    // One-hot select {rf, m, w}; a load in M cannot forward, the stall covers it.
    function automatic logic [2:0] mux_sel(
        input logic hitm,
        input logic hitw,
        input logic load_m
    );
        logic sel_m;
        logic sel_w;
        sel_m = hitm & ~load_m;
        sel_w = hitw & ~hitm;
        return {~sel_m & ~sel_w, sel_m, sel_w};
    endfunction

    // Hazard detection, M-stage write qualifier and operand mux selects.
    always_comb begin
        hitm_rs1_s  = reg_hit(rs1_ren_e, wen_m_r, rd_m_r, rs1_e);
        hitm_rs2_s  = reg_hit(rs2_ren_e, wen_m_r, rd_m_r, rs2_e);
        hitw_rs1_s  = reg_hit(rs1_ren_e, wen_w_r, rd_w_r, rs1_e);
        hitw_rs2_s  = reg_hit(rs2_ren_e, wen_w_r, rd_w_r, rs2_e);
        ldu_stall_s = valid_e & ~flush_e & load_m_r & (hitm_rs1_s | hitm_rs2_s);
        wen_qual_s  = valid_e & wen_e & ~flush_e & ~ldu_stall_s & (rd_e != REG_X0);
        rs1_sel_s   = mux_sel(hitm_rs1_s, hitw_rs1_s, load_m_r);
        rs2_sel_s   = mux_sel(hitm_rs2_s, hitw_rs2_s, load_m_r);
    end

    // M and W pipeline registers; hold freezes both, a stall bubbles M only.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_m_r   <= REG_X0;
            wen_m_r  <= 1'b0;
            load_m_r <= 1'b0;
            rd_w_r   <= REG_X0;
            wen_w_r  <= 1'b0;
        end else if (hold) begin
            rd_m_r   <= rd_m_r;
            wen_m_r  <= wen_m_r;
            load_m_r <= load_m_r;
            rd_w_r   <= rd_w_r;
            wen_w_r  <= wen_w_r;
        end else begin
            rd_w_r   <= rd_m_r;
            wen_w_r  <= wen_m_r;
            rd_m_r   <= rd_e;
            wen_m_r  <= wen_qual_s;
            load_m_r <= wen_qual_s & load_e;
        end
    end

    assign rd_m  = rd_m_r;
    assign wen_m = wen_m_r;
    assign rd_w  = rd_w_r;
    assign wen_w = wen_w_r;

    assign ecl_byp_rs1_mux_sel_rf = rs1_sel_s[2];
    assign ecl_byp_rs1_mux_sel_m  = rs1_sel_s[1];
    assign ecl_byp_rs1_mux_sel_w  = rs1_sel_s[0];
    assign ecl_byp_rs2_mux_sel_rf = rs2_sel_s[2];
    assign ecl_byp_rs2_mux_sel_m  = rs2_sel_s[1];
    assign ecl_byp_rs2_mux_sel_w  = rs2_sel_s[0];
    assign ldu_stall_e            = ldu_stall_s;

endmodule

// File: tb/tb_c7bexu_ecl_byp.sv
// Directed table-driven bench for c7bexu_ecl_byp plus a short load-use
// stall-length sequence.
module tb_c7bexu_ecl_byp;

    localparam logic [2:0] RF = 3'b100;
    localparam logic [2:0] SM = 3'b010;
    localparam logic [2:0] SW = 3'b001;

    logic       clk = 1'b0;
    logic       reset, valid_e, wen_e, load_e, flush_e, hold;
    logic       rs1_ren_e, rs2_ren_e;
    logic [4:0] rd_e, rs1_e, rs2_e;
    logic [4:0] rd_m, rd_w;
    logic       wen_m, wen_w, ldu_stall_e;
    logic       s1_rf, s1_m, s1_w, s2_rf, s2_m, s2_w;

    int checks = 0;
    int errors = 0;

    c7bexu_ecl_byp #(.AW(5)) dut (
        .clk(clk), .reset(reset), .valid_e(valid_e), .rd_e(rd_e), .wen_e(wen_e),
        .load_e(load_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rs1_ren_e(rs1_ren_e),
        .rs2_ren_e(rs2_ren_e), .flush_e(flush_e), .hold(hold),
        .rd_m(rd_m), .wen_m(wen_m), .rd_w(rd_w), .wen_w(wen_w),
        .ecl_byp_rs1_mux_sel_rf(s1_rf), .ecl_byp_rs1_mux_sel_m(s1_m),
        .ecl_byp_rs1_mux_sel_w(s1_w), .ecl_byp_rs2_mux_sel_rf(s2_rf),
        .ecl_byp_rs2_mux_sel_m(s2_m), .ecl_byp_rs2_mux_sel_w(s2_w),
        .ldu_stall_e(ldu_stall_e)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, hold, valid, flush, wen, load;
        logic [4:0] rd, rs1;
        logic       ren1;
        logic [4:0] rs2;
        logic       ren2;
        logic [4:0] e_rd_m;
        logic       e_wen_m;
        logic [4:0] e_rd_w;
        logic       e_wen_w;
        logic [2:0] e_s1, e_s2;
        logic       e_stall;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, hold_i, valid, flush, wen, load,
                       input logic [4:0] rd, rs1, input logic ren1,
                       input logic [4:0] rs2, input logic ren2,
                       input logic [4:0] erdm, input logic ewenm,
                       input logic [4:0] erdw, input logic ewenw,
                       input logic [2:0] es1, es2, input logic estall);
        vec_t v;
        v.rst = rst; v.hold = hold_i; v.valid = valid; v.flush = flush;
        v.wen = wen; v.load = load; v.rd = rd; v.rs1 = rs1; v.ren1 = ren1;
        v.rs2 = rs2; v.ren2 = ren2; v.e_rd_m = erdm; v.e_wen_m = ewenm;
        v.e_rd_w = erdw; v.e_wen_w = ewenw; v.e_s1 = es1; v.e_s2 = es2;
        v.e_stall = estall;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; hold = v.hold; valid_e = v.valid; flush_e = v.flush;
        wen_e = v.wen; load_e = v.load; rd_e = v.rd; rs1_e = v.rs1;
        rs1_ren_e = v.ren1; rs2_e = v.rs2; rs2_ren_e = v.ren2;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        vec_t v;
        logic [18:0] got, exp;
        int stall_cycles;
        logic saw_w;

        //   rst hld val fl wen ld rd rs1 r1 rs2 r2 | rd_m wm rd_w ww s1 s2 stall
        add(1,0,0,0,0,0, 0, 0,0, 0,0,   0,0, 0,0, RF,RF,0);  // reset state
        add(0,0,1,0,1,0, 3, 0,0, 0,0,   0,0, 0,0, RF,RF,0);
        add(0,0,1,0,0,0, 0, 1,1, 2,1,   3,1, 0,0, RF,RF,0);  // no hazard
        add(0,0,1,0,1,0, 5, 0,0, 0,0,   0,0, 3,1, RF,RF,0);
        add(0,0,1,0,0,0, 0, 5,1, 3,1,   5,1, 0,0, SM,RF,0);  // M bypass
        add(0,0,0,0,0,0, 0, 5,1, 0,0,   0,0, 5,1, SW,RF,0);  // W bypass
        add(0,0,1,0,1,0, 9, 0,0, 0,0,   0,0, 0,0, RF,RF,0);
        add(0,0,1,0,1,0, 9, 0,0, 0,0,   9,1, 0,0, RF,RF,0);
        add(0,0,1,0,0,0, 0, 9,1, 9,1,   9,1, 9,1, SM,SM,0);  // M over W
        add(0,0,0,0,0,0, 0, 0,0, 9,1,   0,0, 9,1, RF,SW,0);
        add(0,0,1,0,1,1, 7, 0,0, 0,0,   0,0, 0,0, RF,RF,0);  // load rd=7
        add(0,0,1,0,1,0, 8, 7,1, 0,0,   7,1, 0,0, RF,RF,1);  // load-use stall
        add(0,0,1,0,1,0, 8, 7,1, 0,0,   8,0, 7,1, SW,RF,0);  // bubble, W fwd
        add(0,0,0,0,0,0, 0, 0,0, 0,0,   8,1, 8,0, RF,RF,0);
        add(0,0,0,0,0,0, 0, 0,0, 0,0,   0,0, 8,1, RF,RF,0);
        add(0,0,1,0,1,0, 0, 0,0, 0,0,   0,0, 0,0, RF,RF,0);  // rd_e = x0
        add(0,0,1,0,0,0, 0, 0,1, 0,1,   0,0, 0,0, RF,RF,0);
        add(0,0,1,1,1,0, 4, 0,0, 0,0,   0,0, 0,0, RF,RF,0);  // flush rd=4
        add(0,0,0,0,0,0, 0, 4,1, 0,0,   4,0, 0,0, RF,RF,0);
        add(0,0,0,0,0,0, 0, 0,0, 0,0,   0,0, 4,0, RF,RF,0);
        add(0,0,1,0,1,1, 7, 0,0, 0,0,   0,0, 0,0, RF,RF,0);
        add(0,0,1,1,1,0, 2, 7,1, 0,0,   7,1, 0,0, RF,RF,0);  // flush kills stall
        add(0,0,0,0,0,0, 0, 7,1, 0,0,   2,0, 7,1, SW,RF,0);
        add(0,0,0,0,0,0, 0, 0,0, 0,0,   0,0, 2,0, RF,RF,0);
        add(0,0,1,0,1,0, 6, 0,0, 0,0,   0,0, 0,0, RF,RF,0);
        add(0,1,1,0,1,0,10, 6,1, 0,0,   6,1, 0,0, SM,RF,0);  // hold x3
        add(0,1,1,0,1,0,10, 6,1, 0,0,   6,1, 0,0, SM,RF,0);
        add(0,1,1,0,1,0,10, 6,1, 0,0,   6,1, 0,0, SM,RF,0);
        add(0,0,1,0,0,0, 0, 6,1, 0,0,   6,1, 0,0, SM,RF,0);
        add(0,0,0,0,0,0, 0, 0,0, 0,0,   0,0, 6,1, RF,RF,0);
        add(0,0,1,0,1,1, 7, 0,0, 0,0,   0,0, 0,0, RF,RF,0);
        add(0,1,1,0,0,0, 0, 7,1, 0,0,   7,1, 0,0, RF,RF,1);  // stall under hold
        add(0,0,1,0,0,0, 0, 7,1, 0,0,   7,1, 0,0, RF,RF,1);
        add(0,0,1,0,0,0, 0, 7,1, 0,0,   0,0, 7,1, SW,RF,0);
        add(0,0,1,0,1,1, 7, 0,0, 0,0,   0,0, 0,0, RF,RF,0);
        add(1,0,1,0,0,0, 0, 7,1, 7,1,   7,1, 0,0, RF,RF,1);  // reset mid-stall
        add(0,0,1,0,0,0, 0, 7,1, 7,1,   0,0, 0,0, RF,RF,0);

        v = vecs[0];
        drive(v);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v);
            @(negedge clk);
            got = {rd_m, wen_m, rd_w, wen_w, s1_rf, s1_m, s1_w, s2_rf, s2_m, s2_w, ldu_stall_e};
            exp = {v.e_rd_m, v.e_wen_m, v.e_rd_w, v.e_wen_w, v.e_s1, v.e_s2, v.e_stall};
            check($sformatf("vec%0d", i), {13'd0, got}, {13'd0, exp});
            @(posedge clk);
            #1;
        end

        // Load rd=11 followed by an rs2 consumer: stall exactly one cycle, then W forward.
        reset = 0; hold = 0; flush_e = 0; valid_e = 1; wen_e = 1; load_e = 1;
        rd_e = 5'd11; rs1_ren_e = 0; rs2_ren_e = 0; rs1_e = 5'd0; rs2_e = 5'd0;
        @(posedge clk);
        #1;
        wen_e = 0; load_e = 0; rd_e = 5'd0; rs2_e = 5'd11; rs2_ren_e = 1;
        stall_cycles = 0;
        saw_w = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("onehot_rs1_c%0d", c), {31'd0, $onehot({s1_rf, s1_m, s1_w})}, 32'd1);
            check($sformatf("onehot_rs2_c%0d", c), {31'd0, $onehot({s2_rf, s2_m, s2_w})}, 32'd1);
            if (ldu_stall_e) stall_cycles++;
            if (c == 1) saw_w = s2_w;
            @(posedge clk);
            #1;
        end
        check("stall_len", stall_cycles, 32'd1);
        check("w_fwd_after_stall", {31'd0, saw_w}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/c7bexu_ecl_byp.md
Name: c7bexu_ecl_byp

Overview:
- Execution-control companion to the c7bexu_byp data mux; this is the producer side of the bypass interface.
- Pipelines each instruction's destination register, write enable and load flag from E to M to W.
- Drives rd_m/rd_w/wen_m/wen_w and one-hot rs1/rs2 mux selects (RF / M / W) toward the datapath.
- Detects load-use hazards and stalls E until load data is available in W.

Parameters:
- AW, 5, register-address width (x0 hardwired zero).

Ports:
- clk  input  1  core clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_e  input  1  E stage holds a real instruction.
- rd_e  input  AW  E destination register.
- wen_e  input  1  E instruction writes rd.
- load_e  input  1  E instruction is a load (result valid only in W).
- rs1_e  input  AW  E source 1.
- rs2_e  input  AW  E source 2.
- rs1_ren_e  input  1  E reads rs1.
- rs2_ren_e  input  1  E reads rs2.
- flush_e  input  1  kill E instruction (branch/trap redirect).
- hold  input  1  external memory stall; freezes M and W.
- rd_m  output  AW  M destination register.
- wen_m  output  1  M will write rd.
- rd_w  output  AW  W destination register.
- wen_w  output  1  W writes rd.
- ecl_byp_rs1_mux_sel_rf  output  1  rs1 from register file.
- ecl_byp_rs1_mux_sel_m  output  1  rs1 from M result.
- ecl_byp_rs1_mux_sel_w  output  1  rs1 from W result.
- ecl_byp_rs2_mux_sel_rf  output  1  rs2 from register file.
- ecl_byp_rs2_mux_sel_m  output  1  rs2 from M result.
- ecl_byp_rs2_mux_sel_w  output  1  rs2 from W result.
- ldu_stall_e  output  1  load-use stall; E must hold.

Behaviour:
- State: M register {rd_m, wen_m, load_m}; W register {rd_w, wen_w}.
- Reset (synchronous): rd_m=rd_w=0, wen_m=wen_w=load_m=0.
- After reset, selects resolve to rf=1, m=0, w=0; ldu_stall_e=0.
- Advance, when hold=0, each rising edge:
  - W <= M.
  - M <= E with wen_m <= valid_e & wen_e & ~flush_e & ~ldu_stall_e & (rd_e!=0).
  - load_m <= same qualifier & load_e.
  - rd_m <= rd_e, rd_m always captured.
- Hold: hold=1 freezes M and W entirely (no bubble, no advance). hold has priority over ldu_stall_e and flush_e.
- Bubble: ldu_stall_e=1 with hold=0 inserts a bubble in M (wen_m=0, load_m=0) while W advances.
- Match terms (combinational), for rsX in {rs1, rs2}:
  - hitm_X = rsX_ren_e & wen_m & (rd_m==rsX_e) & (rsX_e!=0).
  - hitw_X = rsX_ren_e & wen_w & (rd_w==rsX_e) & (rsX_e!=0).
- Selects:
  - sel_m = hitm_X & ~load_m.
  - sel_w = hitw_X & ~hitm_X.
  - sel_rf = ~sel_m & ~sel_w.
  - M has priority over W (youngest producer wins).
  - Exactly one select per source is high in every cycle, including reset and stall.
- Load in M hitting rsX: sel_m=0, sel_w=0, sel_rf=1 (value ignored; E is stalled).
- ldu_stall_e = valid_e & ~flush_e & load_m & (hitm_rs1 | hitm_rs2).
  - Stalls exactly one cycle for a load; next cycle the load sits in W and sel_w=1.
  - If hold=1 the stall persists until hold drops and the load advances.
- x0 is never bypassed; rd_e=0 never sets wen_m.
- flush_e: the E instruction is never written into M; ldu_stall_e is forced 0.
- Reset mid-stall: state cleared on that edge; stall deasserts the following cycle.
- Latency: M result is visible to the dependent instruction in the next cycle (0 bubbles). A load result is visible after 1 bubble.

Test Plan:
- No hazard: E0 rd=3 wen=1 valid; next cycle rs1=1, rs2=2 -> both sel_rf=1, ldu_stall_e=0; rd_m=3, wen_m=1.
- M bypass: ALU rd=5, then rs1=5 -> rs1_sel_m=1, rs2_sel_rf=1. One cycle later, rd_w=5, wen_w=1.
- M-over-W priority: rd=9 then rd=9 again, then rs2=9 -> rs2_sel_m=1, sel_w=0. Repeat with rs1=rs2=9 -> both sel_m=1.
- Load-use: load rd=7, then rs1=7 -> ldu_stall_e=1 for exactly 1 cycle, wen_m=0 (bubble) the next cycle, then rs1_sel_w=1 and ldu_stall_e=0.
- x0 and flush:
  - wen_e=1, rd_e=0 -> wen_m=0; later rs1=0 -> sel_rf=1.
  - flush_e=1 with rd_e=4 -> wen_m=0 next cycle.
- Hold and reset:
  - hold=1 for 3 cycles with rd_m=6 wen_m=1 -> rd_m/rd_w unchanged, selects stable.
  - reset=1 during a load-use stall -> next cycle wen_m=wen_w=0, ldu_stall_e=0, all sel_rf=1.
